// File: rtl/colour_conversion_sequencer.sv
// YUV->RGB conversion sequencer: walks NCH channel reads per pixel, PIX_PER_GRP pixels per group, NUM_GROUPS per frame.
// Optional macro CCS_STALL_EN: honour mem_ready stalls; when undefined the cadence is a fixed SLOTS cycles per group.
module colour_conversion_sequencer #(
  parameter int NCH         = 3,
  parameter int PIX_PER_GRP = 2,
  parameter int NUM_GROUPS  = 38400,
  parameter int WAIT_CYCLES = 1,
  parameter int GCNT_W      = 16,
  localparam int SLOTS  = NCH * PIX_PER_GRP,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int PIX_W  = (PIX_PER_GRP > 1) ? $clog2(PIX_PER_GRP) : 1,
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int WC_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_ready,
  output logic              clear,
  output logic              busy,
  output logic [CH_W-1:0]   ch_sel,
  output logic [PIX_W-1:0]  pix_sel,
  output logic [SLOTS-1:0]  ld_en,
  output logic              wr_en,
  output logic              temp_en,
  output logic              conv_en,
  output logic [GCNT_W-1:0] grp_cnt,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [WC_W-1:0]    wait_q, wait_d;
  logic [GCNT_W-1:0]  grp_q, grp_d;
  logic               rdy;

`ifdef CCS_STALL_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      ch_q    <= '0;
      pix_q   <= '0;
      wait_q  <= '0;
      grp_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      wait_q  <= wait_d;
      grp_q   <= grp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    wait_d  = wait_q;
    grp_d   = grp_q;
    clear   = 1'b0;
    busy    = 1'b0;
    ch_sel  = '0;
    pix_sel = '0;
    ld_en   = '0;
    wr_en   = 1'b0;
    temp_en = 1'b0;
    conv_en = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        clear = 1'b1;
        if (start) begin
          state_d = S_WAIT;
          grp_d   = '0;
          slot_d  = '0;
          ch_d    = '0;
          pix_d   = '0;
          wait_d  = '0;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_q == WC_W'(WAIT_CYCLES - 1)) begin
          state_d = S_READ;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      S_READ: begin
        busy    = 1'b1;
        ch_sel  = ch_q;
        pix_sel = pix_q;
        // A stalled slot drives no strobes and holds its position.
        if (rdy) begin
          ld_en   = SLOTS'(1) << slot_q;
          wr_en   = ~slot_q[0];
          temp_en = slot_q[0];
          if (slot_q == SLOT_W'(SLOTS - 1)) begin
            conv_en = 1'b1;
            slot_d  = '0;
            ch_d    = '0;
            pix_d   = '0;
            grp_d   = grp_q + GCNT_W'(1);
            if (grp_q == GCNT_W'(NUM_GROUPS - 1))
              state_d = S_DONE;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
            if (ch_q == CH_W'(NCH - 1)) begin
              ch_d  = '0;
              pix_d = pix_q + PIX_W'(1);
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grp_cnt = grp_q;

endmodule

// File: tb/tb_colour_conversion_sequencer.sv
// Randomised bench for colour_conversion_sequencer: a queue of expected per-cycle outputs is built per frame and compared cycle by cycle.
module tb_colour_conversion_sequencer;

  localparam int NCH = 3;
  localparam int PPG = 2;
  localparam int NG  = 4;
  localparam int WC  = 1;
  localparam int GW  = 16;
  localparam int SL  = NCH * PPG;

`ifdef CCS_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mem_ready;
  logic          clear, busy, wr_en, temp_en, conv_en, done;
  logic [1:0]    ch_sel;
  logic [0:0]    pix_sel;
  logic [SL-1:0] ld_en;
  logic [GW-1:0] grp_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_grp = 0;

  always #5 clk = ~clk;

  colour_conversion_sequencer #(
    .NCH(NCH), .PIX_PER_GRP(PPG), .NUM_GROUPS(NG), .WAIT_CYCLES(WC), .GCNT_W(GW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready),
    .clear(clear), .busy(busy), .ch_sel(ch_sel), .pix_sel(pix_sel), .ld_en(ld_en),
    .wr_en(wr_en), .temp_en(temp_en), .conv_en(conv_en), .grp_cnt(grp_cnt), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(bit clr, bit bsy, int ch, int pix, int ld,
                                     bit wr, bit tmp, bit cv, int grp, bit dn);
    logic [30:0] v;
    v = {clr, bsy, 2'(ch), 1'(pix), 6'(ld), wr, tmp, cv, 16'(grp), dn};
    return 64'(v);
  endfunction

  function automatic logic [63:0] obs();
    logic [30:0] v;
    v = {clear, busy, ch_sel, pix_sel, ld_en, wr_en, temp_en, conv_en, grp_cnt, done};
    return 64'(v);
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      mem_ready = 1'($urandom);
      @(negedge clk);
      check("idle", obs(), mk(1, 0, 0, 0, 0, 0, 0, 0, exp_grp, 0));
    end
  endtask

  // mode: 0 no stall, 1 random stalls, 2 three-cycle stall on group 1 slot 5, 3 mem_ready held low
  task automatic run_frame(input int fr, input int mode, input bit extra, input int abort_at);
    logic [63:0] expq[$];
    bit          rdyq[$];
    int          stalls = 0;
    int          dones = 0;
    int          done_seen = -1;
    int          k;

    for (int w = 0; w < WC; w++) begin
      expq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      rdyq.push_back(1'($urandom));
    end
    for (int g = 0; g < NG; g++) begin
      for (int s = 0; s < SL; s++) begin
        k = 0;
        if (mode == 1 && $urandom_range(0, 3) == 0) k = $urandom_range(1, 2);
        if (mode == 2 && g == 1 && s == 5) k = 3;
        if (STALL) begin
          for (int j = 0; j < k; j++) begin
            expq.push_back(mk(0, 1, s % NCH, s / NCH, 0, 0, 0, 0, g, 0));
            rdyq.push_back(1'b0);
          end
          stalls += k;
          rdyq.push_back(1'b1);
        end else begin
          rdyq.push_back((k > 0 || mode == 3) ? 1'b0 : 1'b1);
        end
        expq.push_back(mk(0, 1, s % NCH, s / NCH, 1 << s, (s % 2) == 0, (s % 2) == 1,
                          s == SL - 1, g, 0));
      end
    end
    expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, NG, 1));
    rdyq.push_back(1'b1);
    expq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, NG, 0));
    rdyq.push_back(1'b1);

    @(posedge clk); #1;
    start = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check($sformatf("f%0d_start", fr), obs(), mk(1, 0, 0, 0, 0, 0, 0, 0, exp_grp, 0));

    for (int i = 0; i < expq.size(); i++) begin
      @(posedge clk); #1;
      start = (extra && i < expq.size() - 1) ? 1'($urandom) : 1'b0;
      mem_ready = rdyq[i];
      @(negedge clk);
      check($sformatf("f%0d_c%0d", fr, i + 1), obs(), expq[i]);
      if (done === 1'b1) begin
        dones++;
        done_seen = i + 1;
      end
      if (i == abort_at) begin
        #1 rst = 1'b0;
        #1;
        check($sformatf("f%0d_rst_async", fr), obs(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_grp = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        check($sformatf("f%0d_rst_hold", fr), obs(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check($sformatf("f%0d_rst_rel", fr), obs(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check($sformatf("f%0d_rst_nodone", fr), 64'(dones), 64'(0));
        return;
      end
    end
    check($sformatf("f%0d_done_cnt", fr), 64'(dones), 64'(1));
    check($sformatf("f%0d_done_at", fr), 64'(done_seen), 64'(WC + 1 + NG * SL + stalls));
    exp_grp = NG;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mem_ready = 1'b0;
    #($urandom_range(3, 17));
    rst = 1'b0;
    #1;
    check("reset", obs(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle_cycles($urandom_range(3, 6));

    run_frame(0, 0, 1'b0, -1);
    idle_cycles($urandom_range(1, 4));
    run_frame(1, STALL ? 2 : 3, 1'b0, -1);
    idle_cycles(2);
    for (int f = 2; f < 5; f++) begin
      run_frame(f, 1, 1'b1, -1);
      idle_cycles($urandom_range(1, 3));
    end
    run_frame(5, 0, 1'b0, WC + 2 * SL + 3);
    idle_cycles(2);
    run_frame(6, 0, 1'b0, -1);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
